eth_cmd_exec: RTL



---
 rtl/eth_pkg.sv | 29 ++
 rtl/eth_reply_hdr.sv | 42 ++++
 rtl/eth_cmd_exec.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared command codes, FSM encoding and sizing constants for the Ethernet
// command path (used by the wrapper and by eth_cmd_exec).
package eth_pkg;

    localparam logic [2:0] CMD_NONE       = 3'd0;
    localparam logic [2:0] CMD_READ_SDRAM = 3'd1;
    localparam logic [2:0] CMD_READ_REG   = 3'd2;
    localparam logic [2:0] CMD_WRITE_REG  = 3'd3;

    localparam int          ERR_BIT  = 31;
    localparam logic [31:0] MAXWORDS = 32'd360;          // data words per reply packet
    localparam logic [31:0] REG_AMAX = 32'h0000_0FFF;
    localparam logic [32:0] SD_WORDS = 33'h0_0400_0000;  // 33 bits so addr+len wrap is caught
    localparam logic [7:0]  REG_TMO  = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG,
        ST_HDR,
        ST_SDREQ,
        ST_SDDATA
    } state_e;

    // Length of the next reply packet given the words still to send.
    function automatic logic [15:0] pkt_len(input logic [31:0] rem);
        return (rem > MAXWORDS) ? MAXWORDS[15:0] : rem[15:0];
    endfunction

endpackage

// File: rtl/eth_reply_hdr.sv
// Three-word reply header sequencer with a valid/ready handshake.
module eth_reply_hdr (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        last_i,
    input  logic [31:0] w0_i,
    input  logic [31:0] w1_i,
    input  logic [31:0] w2_i,
    input  logic        txready_i,
    output logic [31:0] txd_o,
    output logic        txvld_o,
    output logic        txend_o,
    output logic        done_o
);
    logic [1:0] idx_q, idx_d;

    // Word index register; restarts at word 0 whenever the sequencer is idle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) idx_q <= 2'd0;
        else          idx_q <= idx_d;
    end

    // Advance on each accepted word and present the selected header word.
    always_comb begin
        idx_d = idx_q;
        if (!en_i)          idx_d = 2'd0;
        else if (txready_i) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

        case (idx_q)
            2'd0:    txd_o = w0_i;
            2'd1:    txd_o = w1_i;
            2'd2:    txd_o = w2_i;
            default: txd_o = 32'd0;
        endcase
        if (!en_i) txd_o = 32'd0;
        txvld_o = en_i;
        txend_o = en_i && last_i && (idx_q == 2'd2);
        done_o  = en_i && txready_i && (idx_q == 2'd2);
    end

endmodule

// File: rtl/eth_cmd_exec.sv
// Executes register read/write and SDRAM read commands from the Ethernet
// wrapper and streams the reply packets back. Long SDRAM reads are split
// into packets of at most MAXWORDS data words, each with its own header.
module eth_cmd_exec
    import eth_pkg::*;
(
    input  logic        clk125_i,
    input  logic        reset_n_i,
    input  logic [2:0]  cmd_i,
    input  logic [31:0] address_i,
    input  logic [31:0] value_i,
    output logic        ready4cmd_o,
    output logic [31:0] txd_o,
    output logic        txvld_o,
    output logic        txend_o,
    input  logic        txready_i,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_ack_i,
    output logic        sd_req_o,
    input  logic        sd_gnt_i,
    output logic [31:0] sd_addr_o,
    output logic [15:0] sd_len_o,
    input  logic [31:0] sd_data_i,
    input  logic        sd_vld_i,
    output logic        sd_rdy_o
);
    state_e      state_q, state_d;
    logic [2:0]  c_cmd_q, c_cmd_d;
    logic [31:0] c_adr_q, c_adr_d;   // current packet address
    logic [31:0] c_val_q, c_val_d;   // reg value, or SDRAM words still to send
    logic        err_q, err_d;
    logic        strb_q, strb_d;     // first REG cycle carries the bus strobe
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] cnt_q, cnt_d;       // data words accepted in current burst

    logic [15:0] plen;
    logic        is_sd, hdr_last, hdr_done, hdr_txvld, hdr_txend, acc_err;
    logic [31:0] hdr_w0, hdr_w2, hdr_txd;
    logic [32:0] acc_end;

    assign plen        = pkt_len(c_val_q);
    assign is_sd       = (c_cmd_q == CMD_READ_SDRAM);
    assign hdr_w2      = is_sd ? {16'd0, plen} : c_val_q;
    assign hdr_last    = !is_sd || err_q;
    assign reg_addr_o  = c_adr_q;
    assign reg_wdata_o = c_val_q;

    // Header word 0: error flag over the command code.
    always_comb begin
        hdr_w0          = 32'(c_cmd_q);
        hdr_w0[ERR_BIT] = err_q;
    end

    // Command validation on the incoming request.
    always_comb begin
        acc_end = {1'b0, address_i} + {1'b0, value_i};
        acc_err = 1'b0;
        case (cmd_i)
            CMD_NONE:                    acc_err = 1'b0;
            CMD_READ_SDRAM:              acc_err = (value_i == 32'd0) || (acc_end > SD_WORDS);
            CMD_READ_REG, CMD_WRITE_REG: acc_err = (address_i > REG_AMAX);
            default:                     acc_err = 1'b1;
        endcase
    end

    eth_reply_hdr u_hdr (
        .clk_i     (clk125_i),
        .rst_n_i   (reset_n_i),
        .en_i      (state_q == ST_HDR),
        .last_i    (hdr_last),
        .w0_i      (hdr_w0),
        .w1_i      (c_adr_q),
        .w2_i      (hdr_w2),
        .txready_i (txready_i),
        .txd_o     (hdr_txd),
        .txvld_o   (hdr_txvld),
        .txend_o   (hdr_txend),
        .done_o    (hdr_done)
    );

    // State and command context registers.
    always_ff @(posedge clk125_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            c_cmd_q <= 3'd0;
            c_adr_q <= 32'd0;
            c_val_q <= 32'd0;
            err_q   <= 1'b0;
            strb_q  <= 1'b0;
            tmo_q   <= 8'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            c_cmd_q <= c_cmd_d;
            c_adr_q <= c_adr_d;
            c_val_q <= c_val_d;
            err_q   <= err_d;
            strb_q  <= strb_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and output muxing per state.
    always_comb begin
        state_d     = state_q;
        c_cmd_d     = c_cmd_q;
        c_adr_d     = c_adr_q;
        c_val_d     = c_val_q;
        err_d       = err_q;
        strb_d      = 1'b0;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        ready4cmd_o = 1'b0;
        txd_o       = 32'd0;
        txvld_o     = 1'b0;
        txend_o     = 1'b0;
        reg_wr_o    = 1'b0;
        reg_rd_o    = 1'b0;
        sd_req_o    = 1'b0;
        sd_addr_o   = 32'd0;
        sd_len_o    = 16'd0;
        sd_rdy_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready4cmd_o = 1'b1;
                if (cmd_i != CMD_NONE) begin
                    c_cmd_d = cmd_i;
                    c_adr_d = address_i;
                    c_val_d = value_i;
                    err_d   = acc_err;
                    tmo_d   = 8'd0;
                    cnt_d   = 16'd0;
                    if (!acc_err && (cmd_i == CMD_READ_REG || cmd_i == CMD_WRITE_REG)) begin
                        state_d = ST_REG;
                        strb_d  = 1'b1;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
            end
            ST_REG: begin
                reg_rd_o = strb_q && (c_cmd_q == CMD_READ_REG);
                reg_wr_o = strb_q && (c_cmd_q == CMD_WRITE_REG);
                tmo_d    = tmo_q + 8'd1;
                // An ack on the expiring cycle still wins over the timeout.
                if (reg_ack_i) begin
                    if (c_cmd_q == CMD_READ_REG) c_val_d = reg_rdata_i;
                    state_d = ST_HDR;
                end else if (tmo_q == REG_TMO) begin
                    err_d   = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                txd_o   = hdr_txd;
                txvld_o = hdr_txvld;
                txend_o = hdr_txend;
                if (hdr_done) state_d = hdr_last ? ST_IDLE : ST_SDREQ;
            end
            ST_SDREQ: begin
                sd_req_o  = 1'b1;
                sd_addr_o = c_adr_q;
                sd_len_o  = plen;
                if (sd_gnt_i) state_d = ST_SDDATA;
            end
            ST_SDDATA: begin
                txd_o    = sd_data_i;
                txvld_o  = sd_vld_i;
                sd_rdy_o = txready_i;
                txend_o  = sd_vld_i && (cnt_q == plen - 16'd1);
                if (sd_vld_i && txready_i) begin
                    if (cnt_q == plen - 16'd1) begin
                        cnt_d   = 16'd0;
                        c_val_d = c_val_q - {16'd0, plen};
                        c_adr_d = c_adr_q + {16'd0, plen};
                        state_d = (c_val_q == {16'd0, plen}) ? ST_IDLE : ST_HDR;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
